// File: rtl/fwd_bypass_net.sv
// Priority operand-bypass network: M > W > retired-write history > register file,
// with the higher lane winning inside a stage. History is built only with FWD_HIST_EN.
module fwd_bypass_net #(
    parameter int LANES      = 2,
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int HIST_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [LANES*2*REG_AW-1:0] rs_e,
    input  logic [LANES*2*XLEN-1:0]   rf_data_e,
    input  logic [LANES*REG_AW-1:0]   rd_m,
    input  logic [LANES-1:0]          regwrite_m,
    input  logic [LANES*XLEN-1:0]     aluresult_m,
    input  logic [LANES*REG_AW-1:0]   rd_w,
    input  logic [LANES-1:0]          regwrite_w,
    input  logic [LANES*XLEN-1:0]     result_w,
    output logic [LANES*2*XLEN-1:0]   opnd_e,
    output logic [LANES*2*2-1:0]      fwd_src_e,
    output logic [15:0]               fwd_hits_o
);

    localparam int NOPS = 2 * LANES;

    localparam logic [1:0] SRC_RF   = 2'b00;
    localparam logic [1:0] SRC_W    = 2'b01;
    localparam logic [1:0] SRC_M    = 2'b10;
    localparam logic [1:0] SRC_HIST = 2'b11;

`ifdef FWD_HIST_EN
    logic [LANES-1:0]  hist_vld_q  [HIST_DEPTH];
    logic [REG_AW-1:0] hist_rd_q   [HIST_DEPTH][LANES];
    logic [XLEN-1:0]   hist_data_q [HIST_DEPTH][LANES];

    // Only the valid bits need reset/flush; tags and data are meaningless without them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int h = 0; h < HIST_DEPTH; h++) begin
                hist_vld_q[h] <= '0;
            end
        end else if (flush_i) begin
            for (int h = 0; h < HIST_DEPTH; h++) begin
                hist_vld_q[h] <= '0;
            end
        end else if (!stall_i) begin
            hist_vld_q[0] <= regwrite_w;
            for (int h = 1; h < HIST_DEPTH; h++) begin
                hist_vld_q[h] <= hist_vld_q[h-1];
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_hist_lane
        always_ff @(posedge clk) begin
            if (!stall_i && !flush_i) begin
                hist_rd_q[0][gi]   <= rd_w[gi*REG_AW +: REG_AW];
                hist_data_q[0][gi] <= result_w[gi*XLEN +: XLEN];
                for (int h = 1; h < HIST_DEPTH; h++) begin
                    hist_rd_q[h][gi]   <= hist_rd_q[h-1][gi];
                    hist_data_q[h][gi] <= hist_data_q[h-1][gi];
                end
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = flush_i ^ (HIST_DEPTH > 0);
`endif

    // Candidates are scanned lowest priority first so the last match wins.
    for (genvar gi = 0; gi < NOPS; gi++) begin : g_opnd
        logic [REG_AW-1:0] rs;
        logic [1:0]        sel_src;
        logic [XLEN-1:0]   sel_data;

        assign rs = rs_e[gi*REG_AW +: REG_AW];

        always_comb begin
            sel_src  = SRC_RF;
            sel_data = rf_data_e[gi*XLEN +: XLEN];
            if (rs != '0) begin
`ifdef FWD_HIST_EN
                for (int h = HIST_DEPTH - 1; h >= 0; h--) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (hist_vld_q[h][l] && hist_rd_q[h][l] == rs) begin
                            sel_src  = SRC_HIST;
                            sel_data = hist_data_q[h][l];
                        end
                    end
                end
`endif
                for (int l = 0; l < LANES; l++) begin
                    if (regwrite_w[l] && rd_w[l*REG_AW +: REG_AW] == rs) begin
                        sel_src  = SRC_W;
                        sel_data = result_w[l*XLEN +: XLEN];
                    end
                end
                for (int l = 0; l < LANES; l++) begin
                    if (regwrite_m[l] && rd_m[l*REG_AW +: REG_AW] == rs) begin
                        sel_src  = SRC_M;
                        sel_data = aluresult_m[l*XLEN +: XLEN];
                    end
                end
            end
        end

        assign opnd_e[gi*XLEN +: XLEN] = sel_data;
        assign fwd_src_e[gi*2 +: 2]    = sel_src;
    end

    logic        any_fwd;
    logic [15:0] hits_q;
    logic [15:0] hits_d;

    assign any_fwd = |fwd_src_e;

    always_comb begin
        hits_d = hits_q;
        if (!stall_i && any_fwd && hits_q != 16'hFFFF) begin
            hits_d = hits_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hits_q <= '0;
        end else begin
            hits_q <= hits_d;
        end
    end

    assign fwd_hits_o = hits_q;

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Directed bench for fwd_bypass_net (LANES=2, XLEN=32, REG_AW=5, HIST_DEPTH=2);
// history expectations follow FWD_HIST_EN.
module tb_fwd_bypass_net;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int AW    = 5;

`ifdef FWD_HIST_EN
    localparam logic [1:0] HSRC = 2'b11;
    localparam bit         HIST = 1'b1;
`else
    localparam logic [1:0] HSRC = 2'b00;
    localparam bit         HIST = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     stall_i;
    logic                     flush_i;
    logic [LANES*2*AW-1:0]    rs_e;
    logic [LANES*2*XLEN-1:0]  rf_data_e;
    logic [LANES*AW-1:0]      rd_m;
    logic [LANES-1:0]         regwrite_m;
    logic [LANES*XLEN-1:0]    aluresult_m;
    logic [LANES*AW-1:0]      rd_w;
    logic [LANES-1:0]         regwrite_w;
    logic [LANES*XLEN-1:0]    result_w;
    logic [LANES*2*XLEN-1:0]  opnd_e;
    logic [LANES*2*2-1:0]     fwd_src_e;
    logic [15:0]              fwd_hits_o;

    int errors = 0;
    int checks = 0;

    fwd_bypass_net #(.LANES(LANES), .XLEN(XLEN), .REG_AW(AW), .HIST_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
        .rs_e(rs_e), .rf_data_e(rf_data_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .aluresult_m(aluresult_m),
        .rd_w(rd_w), .regwrite_w(regwrite_w), .result_w(result_w),
        .opnd_e(opnd_e), .fwd_src_e(fwd_src_e), .fwd_hits_o(fwd_hits_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s observed=%h expected=%h ok", tag, obs, exp);
        end else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input int i, input logic [AW-1:0] v);
        rs_e[i*AW +: AW] = v;
    endtask

    task automatic set_m(input int l, input logic [AW-1:0] rd, input logic [31:0] d);
        regwrite_m[l] = 1'b1;
        rd_m[l*AW +: AW] = rd;
        aluresult_m[l*XLEN +: XLEN] = d;
    endtask

    task automatic set_w(input int l, input logic [AW-1:0] rd, input logic [31:0] d);
        regwrite_w[l] = 1'b1;
        rd_w[l*AW +: AW] = rd;
        result_w[l*XLEN +: XLEN] = d;
    endtask

    task automatic clear_fwd();
        regwrite_m = '0; rd_m = '0; aluresult_m = '0;
        regwrite_w = '0; rd_w = '0; result_w = '0;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] op(input int i);
        return opnd_e[i*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] src(input int i);
        return {30'd0, fwd_src_e[i*2 +: 2]};
    endfunction

    function automatic logic [31:0] rf(input int i);
        return 32'h1000_0000 + i;
    endfunction

    initial begin
        reset_n = 1'b0; stall_i = 1'b1; flush_i = 1'b0;
        rs_e = '0;
        clear_fwd();
        for (int i = 0; i < 2*LANES; i++) rf_data_e[i*XLEN +: XLEN] = rf(i);
        #3;
        chk("rst_hits", {16'd0, fwd_hits_o}, 32'd0);
        chk("rst_src", {24'd0, fwd_src_e}, 32'd0);
        chk("rst_opnd0", op(0), rf(0));
        tick();
        reset_n = 1'b1;

        // M beats W on the same register; unrelated operand reads RF
        set_rs(0, 5); set_rs(1, 3);
        set_m(0, 5, 32'hAAAA_0001);
        set_w(0, 5, 32'h0000_BBBB);
        #1;
        chk("m_over_w_op", op(0), 32'hAAAA_0001);
        chk("m_over_w_src", src(0), 32'd2);
        chk("no_match_op", op(1), rf(1));
        chk("no_match_src", src(1), 32'd0);

        // Both M lanes write x7: lane1 wins
        clear_fwd();
        set_rs(0, 7); set_rs(1, 7); set_rs(2, 7); set_rs(3, 0);
        set_m(0, 7, 32'h11); set_m(1, 7, 32'h22);
        #1;
        chk("m_lane1_op0", op(0), 32'h22);
        chk("m_lane1_op2", op(2), 32'h22);
        chk("m_lane1_src1", src(1), 32'd2);

        // x0 never forwarded
        clear_fwd();
        set_rs(0, 0);
        set_m(0, 0, 32'h5555_5555);
        set_w(1, 0, 32'h6666_6666);
        #1;
        chk("x0_op", op(0), rf(0));
        chk("x0_src", src(0), 32'd0);

        // Both W lanes write x4: lane1 wins
        clear_fwd();
        set_rs(2, 4);
        set_w(0, 4, 32'h44);
        set_w(1, 4, 32'h4444);
        #1;
        chk("w_lane1_op", op(2), 32'h4444);
        chk("w_lane1_src", src(2), 32'd1);

        // History lifetime: x9 written in W at cycle n
        clear_fwd();
        rs_e = '0;
        reset_pulse();
        stall_i = 1'b0;
        tick();
        set_rs(0, 9);
        set_w(0, 9, 32'hDEAD_0009);
        #1;
        chk("hist_n_src", src(0), 32'd1);
        tick();
        clear_fwd();
        #1;
        chk("hist_n1_src", src(0), {30'd0, HSRC});
        chk("hist_n1_op", op(0), HIST ? 32'hDEAD_0009 : rf(0));
        tick(); #1;
        chk("hist_n2_src", src(0), {30'd0, HSRC});
        chk("hist_n2_op", op(0), HIST ? 32'hDEAD_0009 : rf(0));
        tick(); #1;
        chk("hist_n3_src", src(0), 32'd0);
        chk("hist_n3_op", op(0), rf(0));

        // Stall at n+1 extends visibility to n+3
        reset_pulse();
        tick();
        set_w(0, 9, 32'hDEAD_0009);
        #1;
        tick();
        clear_fwd();
        stall_i = 1'b1;
        #1;
        chk("stl_n1_src", src(0), {30'd0, HSRC});
        tick();
        stall_i = 1'b0;
        #1;
        chk("stl_n2_src", src(0), {30'd0, HSRC});
        tick(); #1;
        chk("stl_n3_src", src(0), {30'd0, HSRC});
        chk("stl_n3_op", op(0), HIST ? 32'hDEAD_0009 : rf(0));
        tick(); #1;
        chk("stl_n4_src", src(0), 32'd0);

        // Flush clears history
        tick();
        set_w(0, 9, 32'hDEAD_0009);
        #1;
        tick();
        clear_fwd();
        flush_i = 1'b1;
        #1;
        chk("fl_pre_src", src(0), {30'd0, HSRC});
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_post_src", src(0), 32'd0);

        // Flush has priority over stall
        set_w(0, 9, 32'hDEAD_0009);
        #1;
        tick();
        clear_fwd();
        flush_i = 1'b1; stall_i = 1'b1;
        #1;
        chk("flst_pre_src", src(0), {30'd0, HSRC});
        tick();
        flush_i = 1'b0; stall_i = 1'b0;
        #1;
        chk("flst_post_src", src(0), 32'd0);
        chk("flst_post_op", op(0), rf(0));

        // Mid-cycle reset discards history and counter immediately
        set_w(0, 9, 32'hDEAD_0009);
        #1;
        tick();
        clear_fwd();
        #1;
        chk("arst_pre_src", src(0), {30'd0, HSRC});
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_src", src(0), 32'd0);
        chk("arst_op", op(0), rf(0));
        chk("arst_hits", {16'd0, fwd_hits_o}, 32'd0);
        reset_n = 1'b1;

        // Hit counter
        rs_e = '0;
        tick(); #1;
        chk("hits_idle", {16'd0, fwd_hits_o}, 32'd0);
        set_rs(0, 5);
        set_m(0, 5, 32'h1234_5678);
        #1;
        tick(); tick(); tick();
        chk("hits_3", {16'd0, fwd_hits_o}, 32'd3);
        stall_i = 1'b1;
        tick();
        chk("hits_stall", {16'd0, fwd_hits_o}, 32'd3);
        stall_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("hits_flush", {16'd0, fwd_hits_o}, 32'd4);
        repeat (65530) @(posedge clk);
        #1;
        chk("hits_fffe", {16'd0, fwd_hits_o}, 32'h0000_FFFE);
        tick();
        chk("hits_ffff", {16'd0, fwd_hits_o}, 32'h0000_FFFF);
        tick();
        chk("hits_sat", {16'd0, fwd_hits_o}, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
